// File: rtl/spi_reg_port_pkg.sv
// Shared definitions for the SPI register port: instruction field layout,
// frame lengths and the frame-decoder state encoding.
package spi_reg_port_pkg;

  localparam int RW_BIT    = 15;
  localparam int W_MSB     = 14;
  localparam int W_LSB     = 13;
  localparam int INSTR_LEN = 16;
  localparam int BYTE_LEN  = 8;

  localparam logic [1:0] W_STREAM = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INSTR = 2'd1,
    DATA  = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/spi_reg_port_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, with single-cycle
// rise/fall pulses derived from the synchronised level.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  // NOTE: every variable assigned in always_comb gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    prev_d = sync_q[STAGES-1];
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign dout = sync_q[STAGES-1];
  assign rise = dout & ~prev_q;
  assign fall = ~dout & prev_q;

endmodule

// File: rtl/spi_reg_port.sv
// Oversampled SPI slave (ADI 3/4-wire framing) that turns instruction + data
// frames into register-bank enable/write strobes and serialises read-back on SDO.
module spi_reg_port
  import spi_reg_port_pkg::*;
#(
  parameter int ADDR_W      = 13,
  parameter int SYNC_STAGES = 2
) (
  input  logic              I_clk,
  input  logic              I_reset_n,
  input  logic              I_sclk,
  input  logic              I_csb,
  input  logic              I_sdi,
  input  logic [7:0]        I_rdata,
  output logic [ADDR_W-1:0] O_addr,
  output logic              O_enable,
  output logic              O_wen,
  output logic [7:0]        O_wdata,
  output logic              O_sdo,
  output logic              O_sdo_oe
);

  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic csb_s, sdi_s;
  logic [3:0] edge_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(I_clk), .rst_n(I_reset_n), .din(I_sclk),
    .dout(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  // CSB resets to the deselected level so release of reset never looks like a frame start.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csb (
    .clk(I_clk), .rst_n(I_reset_n), .din(I_csb),
    .dout(csb_s), .rise(edge_unused[0]), .fall(edge_unused[1])
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
    .clk(I_clk), .rst_n(I_reset_n), .din(I_sdi),
    .dout(sdi_s), .rise(edge_unused[2]), .fall(edge_unused[3])
  );

  state_e            state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [14:0]       shift_q, shift_d;     // the live SDI bit completes the 16-bit word
  logic              rw_q, rw_d;
  logic [1:0]        wlen_q, wlen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              enable_q, enable_d;
  logic              wen_q, wen_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              sdo_q, sdo_d;
  logic              sdo_oe_q, sdo_oe_d;
  logic [7:0]        sdo_shift_q, sdo_shift_d;
  logic              dec_q, dec_d;
  logic              cap_q, cap_d;

  logic [15:0] instr_next;
  logic        instr_last, byte_last, frame_last;

  assign instr_next = {shift_q, sdi_s};
  assign instr_last = (bit_cnt_q == 4'(INSTR_LEN - 1));
  assign byte_last  = (bit_cnt_q == 4'(BYTE_LEN - 1));
  assign frame_last = (wlen_q != W_STREAM) && (byte_cnt_q == wlen_q);

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // CSB deselect is tested first in every state so it beats a coincident SCLK edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (!csb_s) state_d = INSTR;
      INSTR: begin
        if (csb_s)                          state_d = IDLE;
        else if (sclk_rise && instr_last)   state_d = DATA;
      end
      DATA: begin
        if (csb_s)                                       state_d = IDLE;
        else if (sclk_rise && byte_last && frame_last)   state_d = DONE;
      end
      DONE:  if (csb_s) state_d = IDLE;
    endcase
  end

  // Byte completion launches a short pipeline: strobe, then address step, then read preload.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    wlen_d      = wlen_q;
    addr_d      = addr_q;
    enable_d    = enable_q;
    wen_d       = 1'b0;
    wdata_d     = wdata_q;
    sdo_d       = sdo_q;
    sdo_oe_d    = sdo_oe_q;
    sdo_shift_d = sdo_shift_q;
    dec_d       = 1'b0;
    cap_d       = 1'b0;

    if (dec_q && state_q != IDLE) begin
      addr_d = addr_q - ADDR_W'(1);
      cap_d  = rw_q;
    end
    if (cap_q && state_q != IDLE) sdo_shift_d = I_rdata;

    unique case (state_q)
      IDLE: begin
        bit_cnt_d  = '0;
        byte_cnt_d = '0;
        enable_d   = 1'b0;
        sdo_oe_d   = 1'b0;
        sdo_d      = 1'b0;
      end
      INSTR: begin
        if (!csb_s && sclk_rise) begin
          shift_d   = instr_next[14:0];
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (instr_last) begin
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            addr_d     = instr_next[ADDR_W-1:0];
            enable_d   = 1'b1;
            rw_d       = instr_next[RW_BIT];
            wlen_d     = instr_next[W_MSB:W_LSB];
            cap_d      = instr_next[RW_BIT];
          end
        end
      end
      DATA: begin
        if (csb_s) begin
          enable_d = 1'b0;
          sdo_oe_d = 1'b0;
        end else begin
          if (sclk_rise) begin
            shift_d   = instr_next[14:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (byte_last) begin
              bit_cnt_d  = '0;
              byte_cnt_d = byte_cnt_q + 2'd1;
              dec_d      = 1'b1;
              if (!rw_q) begin
                wen_d   = 1'b1;
                wdata_d = instr_next[7:0];
              end
              if (frame_last) sdo_oe_d = 1'b0;
            end
          end
          if (sclk_fall && rw_q) begin
            sdo_d       = sdo_shift_q[7];
            sdo_shift_d = {sdo_shift_q[6:0], 1'b0};
            sdo_oe_d    = 1'b1;
          end
        end
      end
      DONE: sdo_oe_d = 1'b0;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      shift_q     <= '0;
      rw_q        <= 1'b0;
      wlen_q      <= '0;
      addr_q      <= '0;
      enable_q    <= 1'b0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      sdo_q       <= 1'b0;
      sdo_oe_q    <= 1'b0;
      sdo_shift_q <= '0;
      dec_q       <= 1'b0;
      cap_q       <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      rw_q        <= rw_d;
      wlen_q      <= wlen_d;
      addr_q      <= addr_d;
      enable_q    <= enable_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      sdo_q       <= sdo_d;
      sdo_oe_q    <= sdo_oe_d;
      sdo_shift_q <= sdo_shift_d;
      dec_q       <= dec_d;
      cap_q       <= cap_d;
    end
  end

  assign O_addr   = addr_q;
  assign O_enable = enable_q;
  assign O_wen    = wen_q;
  assign O_wdata  = wdata_q;
  assign O_sdo    = sdo_q;
  assign O_sdo_oe = sdo_oe_q;

endmodule

// File: tb/tb_spi_reg_port.sv
// Directed bench for spi_reg_port: an SPI master drives frames, a frame-level
// model predicts register writes and read-back bytes, a monitor checks every cycle.
module tb_spi_reg_port;

  localparam int HALF = 60;  // SCLK half period: 6 I_clk cycles

  logic        I_clk = 1'b0;
  logic        I_reset_n = 1'b0;
  logic        I_sclk = 1'b0;
  logic        I_csb = 1'b1;
  logic        I_sdi = 1'b0;
  logic [7:0]  I_rdata;
  logic [12:0] O_addr;
  logic        O_enable, O_wen, O_sdo, O_sdo_oe;
  logic [7:0]  O_wdata;

  spi_reg_port #(.ADDR_W(13), .SYNC_STAGES(2)) dut (
    .I_clk(I_clk), .I_reset_n(I_reset_n), .I_sclk(I_sclk), .I_csb(I_csb),
    .I_sdi(I_sdi), .I_rdata(I_rdata), .O_addr(O_addr), .O_enable(O_enable),
    .O_wen(O_wen), .O_wdata(O_wdata), .O_sdo(O_sdo), .O_sdo_oe(O_sdo_oe)
  );

  always #5 I_clk = ~I_clk;

  // Register-mux stand-in: a few addresses return fixed bytes, the rest a hash.
  function automatic logic [7:0] rdata_fn(input logic [12:0] a);
    case (a)
      13'h0001: return 8'h3C;
      13'h0000: return 8'hC3;
      13'h1FFF: return 8'h5A;
      default:  return a[7:0] ^ 8'h96;
    endcase
  endfunction

  assign I_rdata = rdata_fn(O_addr);

  typedef struct {
    logic [12:0] a;
    logic [7:0]  d;
  } wr_t;

  int          n_checks = 0;
  int          n_fail = 0;
  wr_t         exp_wr[$];
  logic [7:0]  exp_rd[8];
  int          n_exp_rd = 0;
  logic [7:0]  tx[8];
  logic [7:0]  rx[8];
  bit          en_window = 1'b0;
  bit          oe_window = 1'b0;
  int          wen_seen = 0;
  logic [12:0] last_wa = '0;
  logic [7:0]  last_wd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: which writes land where, and which bytes a read returns.
  task automatic model_frame(input logic [15:0] instr, input int n_instr, input int n_data);
    int          complete, lim, wl;
    logic [12:0] a;
    wr_t         e;
    wl       = int'(instr[14:13]);
    complete = (n_instr == 16) ? n_data / 8 : 0;
    lim      = (wl == 3) ? complete : ((wl + 1 < complete) ? wl + 1 : complete);
    n_exp_rd = 0;
    for (int i = 0; i < lim; i++) begin
      a = instr[12:0] - 13'(i);
      if (instr[15]) begin
        exp_rd[i] = rdata_fn(a);
        n_exp_rd  = i + 1;
      end else begin
        e.a = a;
        e.d = tx[i];
        exp_wr.push_back(e);
      end
    end
  endtask

  always @(negedge I_clk) begin
    if (O_wen) begin
      wen_seen++;
      last_wa = O_addr;
      last_wd = O_wdata;
      check("wen_expected", 32'(exp_wr.size() != 0), 32'd1);
      if (exp_wr.size() != 0) begin
        check("wen_addr", 32'(O_addr), 32'(exp_wr[0].a));
        check("wen_data", 32'(O_wdata), 32'(exp_wr[0].d));
        void'(exp_wr.pop_front());
      end
    end
    if (!en_window) check("enable_outside_frame", 32'(O_enable), 32'd0);
    if (!oe_window) check("sdo_oe_outside_read", 32'(O_sdo_oe), 32'd0);
  end

  task automatic spi_bit(input logic b, output logic so);
    I_sdi = b;
    #(HALF);
    so = O_sdo;
    I_sclk = 1'b1;
    #(HALF);
    I_sclk = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"},   32'(O_addr),   32'd0);
    check({tag, "_enable"}, 32'(O_enable), 32'd0);
    check({tag, "_wen"},    32'(O_wen),    32'd0);
    check({tag, "_wdata"},  32'(O_wdata),  32'd0);
    check({tag, "_sdo"},    32'(O_sdo),    32'd0);
    check({tag, "_sdo_oe"}, 32'(O_sdo_oe), 32'd0);
  endtask

  task automatic spi_frame(input logic [15:0] instr, input int n_instr, input int n_data,
                           input bit rst_abort);
    logic b;
    model_frame(instr, n_instr, n_data);
    @(negedge I_clk);
    I_csb = 1'b0;
    #(HALF);
    for (int i = 0; i < n_instr; i++) begin
      if (i == 15) begin
        en_window = 1'b1;
        oe_window = instr[15];
      end
      spi_bit(instr[15-i], b);
    end
    for (int j = 0; j < n_data; j++) begin
      spi_bit(tx[j/8][7-(j%8)], b);
      rx[j/8][7-(j%8)] = b;
    end
    if (n_instr == 16 && (n_data % 8) != 0) check("enable_mid_byte", 32'(O_enable), 32'd1);
    if (rst_abort) begin
      @(negedge I_clk);
      I_reset_n = 1'b0;
      #1;
      check_all_zero("reset_mid_frame");
      I_csb = 1'b1;
      repeat (4) @(negedge I_clk);
      en_window = 1'b0;
      oe_window = 1'b0;
      I_reset_n = 1'b1;
    end else begin
      #(HALF);
      I_csb = 1'b1;
      repeat (8) @(negedge I_clk);
      en_window = 1'b0;
      oe_window = 1'b0;
    end
    repeat (6) @(negedge I_clk);
    for (int i = 0; i < n_exp_rd; i++) check("sdo_byte_model", 32'(rx[i]), 32'(exp_rd[i]));
    check("writes_outstanding", 32'(exp_wr.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    repeat (3) @(negedge I_clk);
    check_all_zero("reset");
    I_reset_n = 1'b1;
    repeat (5) @(negedge I_clk);
    check_all_zero("after_reset");

    // Single-byte write
    w0 = wen_seen;
    tx[0] = 8'hA5;
    spi_frame(16'h0014, 16, 8, 1'b0);
    check("single_wen_count", 32'(wen_seen - w0), 32'd1);
    check("single_addr", 32'(last_wa), 32'h014);
    check("single_data", 32'(last_wd), 32'hA5);

    // Three-byte write followed by one extra byte of SCLKs
    w0 = wen_seen;
    tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33; tx[3] = 8'hFF;
    spi_frame(16'h4020, 16, 32, 1'b0);
    check("multi_wen_count", 32'(wen_seen - w0), 32'd3);
    check("multi_last_addr", 32'(last_wa), 32'h01E);
    check("multi_last_data", 32'(last_wd), 32'h33);

    // Streaming read across the address wrap
    w0 = wen_seen;
    tx[0] = 8'h00; tx[1] = 8'h00; tx[2] = 8'h00;
    spi_frame(16'hE001, 16, 24, 1'b0);
    check("read_byte0", 32'(rx[0]), 32'h3C);
    check("read_byte1", 32'(rx[1]), 32'hC3);
    check("read_byte2", 32'(rx[2]), 32'h5A);
    check("read_final_addr", 32'(O_addr), 32'h1FFE);
    check("read_no_wen", 32'(wen_seen - w0), 32'd0);

    // Abort after 5 data bits of a write
    w0 = wen_seen;
    tx[0] = 8'h77;
    spi_frame(16'h0008, 16, 5, 1'b0);
    check("abort_data_no_wen", 32'(wen_seen - w0), 32'd0);
    check("abort_data_enable", 32'(O_enable), 32'd0);

    // Abort after 10 instruction bits
    w0 = wen_seen;
    spi_frame(16'h0044, 10, 0, 1'b0);
    check("abort_instr_no_wen", 32'(wen_seen - w0), 32'd0);

    // Reset during the data phase, then a clean frame
    w0 = wen_seen;
    tx[0] = 8'hF0;
    spi_frame(16'h0030, 16, 4, 1'b1);
    check("reset_frame_no_wen", 32'(wen_seen - w0), 32'd0);
    tx[0] = 8'h5C;
    spi_frame(16'h0005, 16, 8, 1'b0);
    check("recover_wen_count", 32'(wen_seen - w0), 32'd1);
    check("recover_addr", 32'(last_wa), 32'h005);
    check("recover_data", 32'(last_wd), 32'h5C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
